mix: RTL and testbench

MIX -- requirements
Module: mix

---
 rtl/mix.sv | 45 ++++
 tb/tb_mix.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mix.sv
// Envelope mixer: DC_POST = min(DC_PRE + ENV*MUL, 2^PWM_DEPTH-1), two register
// stages, one new input set accepted every cycle.
module mix #(
    parameter int PWM_DEPTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           ENV,
    input  logic [PWM_DEPTH-1:0] DC_PRE,
    input  logic [4:0]           MUL,
    output logic [PWM_DEPTH-1:0] DC_POST
);

    localparam int PROD_W = 12;

    logic [PROD_W-1:0]    w_prod;
    logic [PWM_DEPTH:0]   w_sum;
    logic [PWM_DEPTH-1:0] w_sat;

    logic [PROD_W-1:0]    r_prod;
    logic [PWM_DEPTH-1:0] r_dc_pre;
    logic [PWM_DEPTH-1:0] r_dc_post;

    // 127*31 = 3937 fits in 12 bits, so the product never overflows.
    assign w_prod = {5'b0, ENV} * {7'b0, MUL};

    // One extra bit keeps the carry; a set carry means the limit was exceeded.
    assign w_sum  = {1'b0, r_dc_pre} + {{(PWM_DEPTH + 1 - PROD_W){1'b0}}, r_prod};
    assign w_sat  = w_sum[PWM_DEPTH] ? {PWM_DEPTH{1'b1}} : w_sum[PWM_DEPTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod    <= '0;
            r_dc_pre  <= '0;
            r_dc_post <= '0;
        end else begin
            r_prod    <= w_prod;
            r_dc_pre  <= DC_PRE;
            r_dc_post <= w_sat;
        end
    end

    assign DC_POST = r_dc_post;

endmodule

// File: tb/tb_mix.sv
// Randomized self-checking bench for mix: a two-deep queue of expected values
// computed with plain integer arithmetic models the fixed two-cycle latency.
module tb_mix;

    localparam int W     = 12;
    localparam int LIMIT = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic [6:0]   ENV;
    logic [W-1:0] DC_PRE;
    logic [4:0]   MUL;
    logic [W-1:0] DC_POST;

    int checkCount = 0;
    int errorCount = 0;
    int expQueue[$];

    mix #(.PWM_DEPTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ENV     (ENV),
        .DC_PRE  (DC_PRE),
        .MUL     (MUL),
        .DC_POST (DC_POST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mixModel(input int env, input int pre, input int mul);
        int s;
        s = pre + env * mul;
        return (s > LIMIT) ? LIMIT : s;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // At each falling edge the output reflects the inputs driven two falling edges earlier.
    task automatic applyStimulus(input int env, input int pre, input int mul, input string tag);
        int expVal;
        @(negedge clk);
        expVal = expQueue.pop_front();
        checkOutput(tag, 32'(DC_POST), expVal);
        ENV    = 7'(env);
        DC_PRE = W'(pre);
        MUL    = 5'(mul);
        expQueue.push_back(mixModel(env, pre, mul));
    endtask

    initial begin
        int env;
        int pre;
        int mul;

        rst_n  = 1'b0;
        ENV    = 7'd0;
        DC_PRE = '0;
        MUL    = 5'd0;
        #1;
        checkOutput("reset_async", 32'(DC_POST), 0);

        ENV    = 7'd127;
        DC_PRE = W'(4000);
        MUL    = 5'd31;
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", 32'(DC_POST), 0);

        ENV    = 7'd0;
        DC_PRE = '0;
        MUL    = 5'd0;
        rst_n  = 1'b1;
        expQueue = '{0, 0};

        repeat (4) applyStimulus(2, 5, 4, "basic_13");
        applyStimulus(125, 255, 31, "sat_4130");
        applyStimulus(127, 4095, 31, "sat_max");
        applyStimulus(5, 3940, 31, "exact_limit");
        applyStimulus(5, 3941, 31, "limit_plus1");
        applyStimulus(0, 1234, 31, "env_zero");
        applyStimulus(100, 777, 0, "mul_zero");
        applyStimulus(1, 0, 1, "lat_0");
        applyStimulus(1, 10, 1, "lat_10");
        applyStimulus(1, 20, 1, "lat_20");
        applyStimulus(0, 0, 0, "flush_a");
        applyStimulus(0, 0, 0, "flush_b");

        for (int i = 0; i < 200; i++) begin
            env = int'($urandom_range(0, 127));
            mul = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0)
                pre = int'($urandom_range(LIMIT - 4000, LIMIT));
            else
                pre = int'($urandom_range(0, LIMIT));
            applyStimulus(env, pre, mul, "random");
        end

        // Reset dropped between edges must clear the output without waiting for a clock.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async", 32'(DC_POST), 0);
        @(posedge clk);
        #1;
        checkOutput("midreset_hold", 32'(DC_POST), 0);

        ENV    = 7'd2;
        DC_PRE = W'(5);
        MUL    = 5'd4;
        @(negedge clk);
        rst_n = 1'b1;
        expQueue = '{0, mixModel(2, 5, 4)};
        repeat (3) applyStimulus(2, 5, 4, "post_reset_13");

        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 127)), int'($urandom_range(0, LIMIT)),
                          int'($urandom_range(0, 31)), "random_post");
        end
        applyStimulus(0, 0, 0, "final_flush_a");
        applyStimulus(0, 0, 0, "final_flush_b");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
